// File: rtl/ips2l_uart_reg_pkg.sv
// Shared constants and state encoding for the UART register bank.
package ips2l_uart_reg_pkg;

  localparam logic [7:0] OP_WR    = 8'h57;
  localparam logic [7:0] OP_RD    = 8'h52;
  localparam logic [7:0] EXT_BASE = 8'h80;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_WRITE,
    S_RD_INT,
    S_RD_REQ,
    S_RD_WAIT,
    S_TX
  } state_t;

endpackage

// File: rtl/ips2l_uart_frame_parser.sv
// Consumes RX bytes (opcode, address, MSB-first data) and presents the
// completed frame with a one-cycle frame_valid on the last consumed byte.
module ips2l_uart_frame_parser
  import ips2l_uart_reg_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_ready,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_req,
  output logic              o_frame_valid,
  output logic [7:0]        o_op,
  output logic [7:0]        o_addr,
  output logic [DATA_W-1:0] o_data
);

  localparam int BYTES = DATA_W / 8;

  state_t            r_state;
  logic              r_is_wr;
  logic [2:0]        r_cnt;
  logic [7:0]        r_addr;
  logic [DATA_W-1:0] r_data;

  logic              w_take;
  logic [DATA_W-1:0] w_data;

  // A byte is taken whenever the bank is idle and the FIFO shows one.
  assign w_take   = i_ready && i_rx_valid;
  assign o_rx_req = w_take;
  assign w_data   = (r_data << 8) | DATA_W'(i_rx_data);

  // Frame ends on the address byte of a read or the last data byte of a write.
  assign o_frame_valid = w_take &&
                         ((r_state == S_ADDR && !r_is_wr) ||
                          (r_state == S_WDATA && r_cnt == 3'(BYTES - 1)));
  assign o_op   = r_is_wr ? OP_WR : OP_RD;
  assign o_addr = (r_state == S_ADDR) ? i_rx_data : r_addr;
  assign o_data = w_data;

  // Byte-level frame state; unknown opcodes are swallowed without leaving IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_is_wr <= 1'b0;
      r_cnt   <= '0;
    end else if (w_take) begin
      case (r_state)
        S_IDLE: begin
          if (i_rx_data == OP_WR) begin
            r_is_wr <= 1'b1;
            r_state <= S_ADDR;
          end else if (i_rx_data == OP_RD) begin
            r_is_wr <= 1'b0;
            r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          r_cnt   <= '0;
          r_state <= r_is_wr ? S_WDATA : S_IDLE;
        end
        S_WDATA: begin
          if (r_cnt == 3'(BYTES - 1)) r_state <= S_IDLE;
          else                        r_cnt   <= r_cnt + 3'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Address and data shift register; contents are meaningless outside a frame.
  always_ff @(posedge clk) begin
    if (w_take) begin
      if (r_state == S_ADDR)  r_addr <= i_rx_data;
      if (r_state == S_WDATA) r_data <= w_data;
    end
  end

endmodule

// File: rtl/ips2l_uart_reg_bank.sv
// UART-driven control register bank: writes local control registers, reads
// them back or forwards reads >= 0x80 to an external status bus.
// Optional feature: define IPS2L_UART_RD_TIMEOUT_EN to bound external reads
// by RD_TIMEOUT cycles, answering all-ones and pulsing rd_timeout on expiry.
module ips2l_uart_reg_bank
  import ips2l_uart_reg_pkg::*;
#(
  parameter int                          DATA_W     = 32,
  parameter int                          NUM_CTRL   = 15,
  parameter logic [NUM_CTRL*DATA_W-1:0]  DFT_CTRL   = '0,
  parameter int                          RD_TIMEOUT = 1023
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   rx_fifo_rd_data,
  input  logic                         rx_fifo_rd_data_valid,
  output logic                         rx_fifo_rd_data_req,
  output logic [DATA_W-1:0]            tx_fifo_wr_data,
  input  logic                         tx_fifo_wr_data_valid,
  output logic                         tx_fifo_wr_data_req,
  output logic                         read_req,
  input  logic                         read_ack,
  output logic [7:0]                   uart_rd_addr,
  input  logic [DATA_W-1:0]            status_bus,
  output logic [NUM_CTRL*DATA_W-1:0]   ctrl_bus,
  output logic                         rd_timeout
);

  state_t                       r_state;
  logic [NUM_CTRL*DATA_W-1:0]   r_ctrl;
  logic [DATA_W-1:0]            r_tx_data;
  logic                         r_read_req;
  logic [7:0]                   r_rd_addr;
  logic [7:0]                   r_addr;
  logic [DATA_W-1:0]            r_wdata;

  logic                         w_frame_valid;
  logic [7:0]                   w_op;
  logic [7:0]                   w_addr;
  logic [DATA_W-1:0]            w_data;
  logic [DATA_W-1:0]            w_rd_word;

  ips2l_uart_frame_parser #(
    .DATA_W (DATA_W)
  ) u_parser (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_ready       (r_state == S_IDLE),
    .i_rx_data     (rx_fifo_rd_data),
    .i_rx_valid    (rx_fifo_rd_data_valid),
    .o_rx_req      (rx_fifo_rd_data_req),
    .o_frame_valid (w_frame_valid),
    .o_op          (w_op),
    .o_addr        (w_addr),
    .o_data        (w_data)
  );

  assign ctrl_bus            = r_ctrl;
  assign tx_fifo_wr_data     = r_tx_data;
  assign tx_fifo_wr_data_req = (r_state == S_TX) && tx_fifo_wr_data_valid;
  assign read_req            = r_read_req;
  assign uart_rd_addr        = r_rd_addr;

  // Local readback: unimplemented addresses below 0x80 read as zero.
  always_comb begin
    w_rd_word = '0;
    for (int k = 0; k < NUM_CTRL; k++) begin
      if (r_addr == 8'(k)) w_rd_word = r_ctrl[k*DATA_W +: DATA_W];
    end
  end

  // Hold the frame's address and data while it is being executed.
  always_ff @(posedge clk) begin
    if (w_frame_valid) begin
      r_addr  <= w_addr;
      r_wdata <= w_data;
    end
  end

`ifdef IPS2L_UART_RD_TIMEOUT_EN
  logic [15:0] r_to_cnt;
  logic        r_rd_timeout;
  assign rd_timeout = r_rd_timeout;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (RD_TIMEOUT == 0);
  assign rd_timeout   = 1'b0;
`endif

  // Command FSM: execute a parsed frame, then hand the response to the TX FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ctrl     <= DFT_CTRL;
      r_tx_data  <= '0;
      r_read_req <= 1'b0;
      r_rd_addr  <= '0;
`ifdef IPS2L_UART_RD_TIMEOUT_EN
      r_to_cnt     <= '0;
      r_rd_timeout <= 1'b0;
`endif
    end else begin
`ifdef IPS2L_UART_RD_TIMEOUT_EN
      r_rd_timeout <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_frame_valid) begin
            if (w_op == OP_WR)          r_state <= S_WRITE;
            else if (w_addr >= EXT_BASE) r_state <= S_RD_REQ;
            else                         r_state <= S_RD_INT;
          end
        end
        S_WRITE: begin
          for (int k = 0; k < NUM_CTRL; k++) begin
            if (r_addr == 8'(k)) r_ctrl[k*DATA_W +: DATA_W] <= r_wdata;
          end
          r_state <= S_IDLE;
        end
        S_RD_INT: begin
          r_tx_data <= w_rd_word;
          r_state   <= S_TX;
        end
        S_RD_REQ: begin
          r_rd_addr  <= r_addr;
          r_read_req <= 1'b1;
`ifdef IPS2L_UART_RD_TIMEOUT_EN
          r_to_cnt   <= '0;
`endif
          r_state    <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (read_ack) begin
            r_read_req <= 1'b0;
            r_tx_data  <= status_bus;
            r_state    <= S_TX;
          end
`ifdef IPS2L_UART_RD_TIMEOUT_EN
          else if (r_to_cnt == 16'(RD_TIMEOUT - 1)) begin
            r_read_req   <= 1'b0;
            r_rd_timeout <= 1'b1;
            r_tx_data    <= '1;
            r_state      <= S_TX;
          end else begin
            r_to_cnt <= r_to_cnt + 16'd1;
          end
`endif
        end
        S_TX: begin
          if (tx_fifo_wr_data_valid) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ips2l_uart_reg_bank.sv
// Directed bench for ips2l_uart_reg_bank with a TX-word scoreboard.
module tb_ips2l_uart_reg_bank;

  localparam int DATA_W   = 32;
  localparam int NUM_CTRL = 15;
  localparam int RD_TO    = 15;

  function automatic logic [NUM_CTRL*DATA_W-1:0] mk_dft();
    logic [NUM_CTRL*DATA_W-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_CTRL; k++) v[k*DATA_W +: DATA_W] = 32'hA5000000 | 32'(k);
    return v;
  endfunction

  localparam logic [NUM_CTRL*DATA_W-1:0] DFT = mk_dft();

  logic                       clk;
  logic                       rst_n;
  logic [7:0]                 rx_fifo_rd_data;
  logic                       rx_fifo_rd_data_valid;
  logic                       rx_fifo_rd_data_req;
  logic [DATA_W-1:0]          tx_fifo_wr_data;
  logic                       tx_fifo_wr_data_valid;
  logic                       tx_fifo_wr_data_req;
  logic                       read_req;
  logic                       read_ack;
  logic [7:0]                 uart_rd_addr;
  logic [DATA_W-1:0]          status_bus;
  logic [NUM_CTRL*DATA_W-1:0] ctrl_bus;
  logic                       rd_timeout;

  ips2l_uart_reg_bank #(
    .DATA_W     (DATA_W),
    .NUM_CTRL   (NUM_CTRL),
    .DFT_CTRL   (DFT),
    .RD_TIMEOUT (RD_TO)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .rx_fifo_rd_data       (rx_fifo_rd_data),
    .rx_fifo_rd_data_valid (rx_fifo_rd_data_valid),
    .rx_fifo_rd_data_req   (rx_fifo_rd_data_req),
    .tx_fifo_wr_data       (tx_fifo_wr_data),
    .tx_fifo_wr_data_valid (tx_fifo_wr_data_valid),
    .tx_fifo_wr_data_req   (tx_fifo_wr_data_req),
    .read_req              (read_req),
    .read_ack              (read_ack),
    .uart_rd_addr          (uart_rd_addr),
    .status_bus            (status_bus),
    .ctrl_bus              (ctrl_bus),
    .rd_timeout            (rd_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_pass  = 0;
  int          n_strobe = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model[NUM_CTRL];
  logic [7:0]  fq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_ctrl(input string tag);
    for (int k = 0; k < NUM_CTRL; k++)
      chk($sformatf("%s_reg%0d", tag, k), ctrl_bus[k*DATA_W +: DATA_W], model[k]);
  endtask

  task automatic reset_model();
    for (int k = 0; k < NUM_CTRL; k++) model[k] = DFT[k*DATA_W +: DATA_W];
  endtask

  // Present one byte from negedge until the DUT takes it; returns on a negedge.
  task automatic send(input logic [7:0] b);
    int w;
    rx_fifo_rd_data       = b;
    rx_fifo_rd_data_valid = 1'b1;
    w = 0;
    #1;
    while (!rx_fifo_rd_data_req && w < 50) begin
      @(negedge clk); #1; w++;
    end
    if (!rx_fifo_rd_data_req) chk("rx_consume", 32'(rx_fifo_rd_data_req), 32'd1);
    else @(negedge clk);
  endtask

  task automatic send_q();
    while (fq.size() != 0) send(fq.pop_front());
    rx_fifo_rd_data_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 60) begin
      @(negedge clk); #1; w++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_read_req();
    int w;
    w = 0;
    while (!read_req && w < 20) begin
      @(negedge clk); w++;
    end
    chk("read_req_up", 32'(read_req), 32'd1);
  endtask

  // Scoreboard: every strobe must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && tx_fifo_wr_data_req) begin
      n_strobe++;
      chk("strobe_gated", 32'(tx_fifo_wr_data_valid), 32'd1);
      if (exp_q.size() == 0) chk("spurious_strobe", 32'(exp_q.size()), 32'd1);
      else                   chk("tx_word", tx_fifo_wr_data, exp_q.pop_front());
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int cnt;
    rst_n                 = 1'b0;
    rx_fifo_rd_data       = 8'h00;
    rx_fifo_rd_data_valid = 1'b0;
    tx_fifo_wr_data_valid = 1'b1;
    read_ack              = 1'b0;
    status_bus            = '0;
    reset_model();
    repeat (3) @(negedge clk);

    // Reset state
    chk_ctrl("reset");
    chk("reset_tx_data", tx_fifo_wr_data, 32'h0);
    chk("reset_read_req", 32'(read_req), 32'd0);
    chk("reset_rd_addr", 32'(uart_rd_addr), 32'd0);
    chk("reset_rd_timeout", 32'(rd_timeout), 32'd0);
    chk("reset_tx_req", 32'(tx_fifo_wr_data_req), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write register 3; update lands the cycle after the last byte
    fq = {8'h57, 8'h03, 8'h12, 8'h34, 8'h56, 8'h78};
    send_q();
    chk("write_not_early", ctrl_bus[3*DATA_W +: DATA_W], model[3]);
    @(negedge clk);
    model[3] = 32'h12345678;
    chk_ctrl("after_write");

    // Readback with TX FIFO full for 10 cycles
    tx_fifo_wr_data_valid = 1'b0;
    exp_q.push_back(32'h12345678);
    fq = {8'h52, 8'h03};
    s0 = n_strobe;
    send_q();
    repeat (10) @(negedge clk);
    chk("no_strobe_while_full", 32'(n_strobe), 32'(s0));
    chk("tx_word_held", tx_fifo_wr_data, 32'h12345678);
    tx_fifo_wr_data_valid = 1'b1;
    wait_drain("rd_local_drained");
    repeat (3) @(negedge clk);
    chk("single_strobe", 32'(n_strobe), 32'(s0 + 1));

    // External read acknowledged five cycles later
    exp_q.push_back(32'hCAFE0001);
    fq = {8'h52, 8'h90};
    send_q();
    wait_read_req();
    chk("ext_rd_addr", 32'(uart_rd_addr), 32'h90);
    repeat (4) @(negedge clk);
    chk("read_req_held", 32'(read_req), 32'd1);
    status_bus = 32'hCAFE0001;
    read_ack   = 1'b1;
    @(negedge clk);
    read_ack   = 1'b0;
    status_bus = 32'h0;
    chk("read_req_dropped", 32'(read_req), 32'd0);
    wait_drain("rd_ext_drained");

    // Stray read_ack while idle must be ignored
    status_bus = 32'h55555555;
    read_ack   = 1'b1;
    repeat (2) @(negedge clk);
    read_ack   = 1'b0;
    status_bus = 32'h0;
    repeat (2) @(negedge clk);
    chk("stray_ack_no_req", 32'(read_req), 32'd0);

    // Unimplemented local address reads zero; register 0 reads its reset value
    exp_q.push_back(32'h0);
    fq = {8'h52, 8'h20};
    send_q();
    wait_drain("rd_zero_drained");
    exp_q.push_back(model[0]);
    fq = {8'h52, 8'h00};
    send_q();
    wait_drain("rd_reg0_drained");

`ifdef IPS2L_UART_RD_TIMEOUT_EN
    // External read without acknowledge times out
    exp_q.push_back(32'hFFFFFFFF);
    fq = {8'h52, 8'h90};
    send_q();
    wait_read_req();
    cnt = 0;
    while (!rd_timeout && cnt < 40) begin
      @(negedge clk); cnt++;
    end
    chk("timeout_cycles", 32'(cnt), 32'(RD_TO));
    chk("timeout_read_req_low", 32'(read_req), 32'd0);
    @(negedge clk);
    chk("timeout_pulse_one_cycle", 32'(rd_timeout), 32'd0);
    wait_drain("timeout_drained");
`else
    cnt = 0;
`endif

    // Bad opcode swallowed, write to out-of-range address dropped
    fq = {8'h41, 8'h57, 8'h20, 8'h00, 8'h00, 8'h00, 8'h01};
    send_q();
    repeat (3) @(negedge clk);
    chk_ctrl("after_drop");

    // Reset mid-frame discards the partial write
    fq = {8'h57, 8'h05, 8'hAA};
    send_q();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_model();
    chk_ctrl("mid_frame_reset");
    chk("mid_reset_tx_data", tx_fifo_wr_data, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    fq = {8'h57, 8'h05, 8'h00, 8'h00, 8'h00, 8'h07};
    send_q();
    @(negedge clk);
    model[5] = 32'h00000007;
    chk_ctrl("after_reset_write");

    repeat (3) @(negedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
